// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port integer register file with per-register pending bits.
// A post-reset sweep clears the array one entry per cycle before use.
module regfile_mp_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
);

  typedef enum logic {
    SWEEP,
    READY
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_nx;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic            we;
  logic            rs;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      SWEEP: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == AW'(NREGS - 1))
          state_nx = READY;
      end
      READY: ;
      default: state_nx = SWEEP;
    endcase
  end

  assign ready = (state == READY);

  // Register 0 never accepts writes or reservations when hardwired
  assign we = ready && wr_en &&
              !((ZERO_REG != 0) && (wr_addr == '0));
  assign rs = ready && rsv_en &&
              !((ZERO_REG != 0) && (rsv_addr == '0));

  always_ff @(posedge clock) begin
    if (state == SWEEP)
      regs[cnt] <= '0;
    else if (we)
      regs[wr_addr] <= wr_data;
  end

  // Reserve is applied last so it wins over a same-cycle write
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      if (we)
        pend[wr_addr] <= 1'b0;
      if (rs)
        pend[rsv_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          z;
    logic          b;
    assign a = rd_addr[k*AW +: AW];
    assign z = (ZERO_REG != 0) && (a == '0);
    assign b = (BYPASS != 0) && we && (a == wr_addr);
    assign rd_data[k*XLEN +: XLEN] =
      (!ready || z) ? '0 : (b ? wr_data : regs[a]);
    assign rd_pend[k] = ready && !z && !b && pend[a];
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: default, no-bypass and
// wide 3-port/16-entry instances, table vectors through a queue.
module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_pend_a;
  logic [1:0]  rd_pend_b;
  logic        ready_a;
  logic        ready_b;

  logic         w2_en;
  logic [3:0]   w2_addr;
  logic [63:0]  w2_data;
  logic         r2_en;
  logic [3:0]   r2_addr;
  logic [11:0]  rd2_addr;
  logic [191:0] rd2_data;
  logic [2:0]   rd2_pend;
  logic         ready_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_scoreboard u_a (
    .clock(clk), .reset_n(reset_n), .ready(ready_a),
    .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_pend(rd_pend_a), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  regfile_mp_scoreboard #(.BYPASS(0)) u_b (
    .clock(clk), .reset_n(reset_n), .ready(ready_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_pend(rd_pend_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  regfile_mp_scoreboard #(
    .XLEN(64), .NREGS(16), .NRD(3)
  ) u_c (
    .clock(clk), .reset_n(reset_n), .ready(ready_c),
    .rd_addr(rd2_addr), .rd_data(rd2_data),
    .rd_pend(rd2_pend), .wr_en(w2_en),
    .wr_addr(w2_addr), .wr_data(w2_data),
    .rsv_en(r2_en), .rsv_addr(r2_addr)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        p0;
    logic        p1;
    logic [31:0] nb0;
  } vec_t;

  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] d2;
  } exp3_t;

  vec_t  vt [16];
  vec_t  q [$];
  exp3_t q3 [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic re,
    input logic [4:0] ra, input logic [4:0] a0,
    input logic [4:0] a1, input logic [31:0] d0,
    input logic [31:0] d1, input logic p0,
    input logic p1, input logic [31:0] nb0);
    vec_t v;
    v = {we, wa, wd, re, ra, a0, a1, d0, d1, p0, p1, nb0};
    return v;
  endfunction

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rsv_en  = 1'b0;
    rsv_addr = '0;
    w2_en   = 1'b0;
    w2_addr = '0;
    w2_data = '0;
    r2_en   = 1'b0;
    r2_addr = '0;
  endtask

  task automatic wr2(input logic [3:0] a,
                     input logic [63:0] d);
    @(posedge clk); #1;
    w2_en   = 1'b1;
    w2_addr = a;
    w2_data = d;
    @(posedge clk); #1;
    w2_en = 1'b0;
  endtask

  task automatic rd3(input logic [3:0] a0,
                     input logic [3:0] a1,
                     input logic [3:0] a2,
                     input logic [63:0] e0,
                     input logic [63:0] e1,
                     input logic [63:0] e2);
    exp3_t e;
    rd2_addr = {a2, a1, a0};
    q3.push_back({e0, e1, e2});
    @(negedge clk);
    e = q3.pop_front();
    chk("c_port0", rd2_data[63:0], e.d0);
    chk("c_port1", rd2_data[127:64], e.d1);
    chk("c_port2", rd2_data[191:128], e.d2);
  endtask

  initial begin
    vec_t e;
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 5,
                32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 5, 5,
                32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    vt[2]  = mk(1, 0, 32'h1234, 0, 0, 0, 5,
                0, 32'hDEADBEEF, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(1, 7, 32'hA5A5A5A5, 0, 0, 7, 5,
                32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 7, 7,
                32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5);
    vt[6]  = mk(0, 0, 0, 1, 3, 3, 3, 0, 0, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
    vt[8]  = mk(1, 3, 32'h10, 0, 0, 3, 3,
                32'h10, 32'h10, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 3, 3,
                32'h10, 32'h10, 0, 0, 32'h10);
    vt[10] = mk(1, 3, 32'h22, 1, 3, 3, 5,
                32'h22, 32'hDEADBEEF, 0, 0, 32'h10);
    vt[11] = mk(0, 0, 0, 0, 0, 3, 3,
                32'h22, 32'h22, 1, 1, 32'h22);
    vt[12] = mk(0, 0, 0, 1, 0, 0, 3,
                0, 32'h22, 0, 1, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[14] = mk(1, 31, 32'hFFFFFFFF, 0, 0, 31, 1,
                32'hFFFFFFFF, 0, 0, 0, 0);
    vt[15] = mk(0, 0, 0, 0, 0, 31, 31,
                32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF);

    idle();
    rd_addr  = '0;
    rd2_addr = '0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", {63'd0, ready_a}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    // writes and reserves during the sweep must be dropped
    wr_en    = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'hCAFEF00D;
    rsv_en   = 1'b1;
    rsv_addr = 5'd6;
    rd_addr  = {5'd6, 5'd5};
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      chk("ready_a", {63'd0, ready_a}, {63'd0, i >= 32});
      chk("ready_b", {63'd0, ready_b}, {63'd0, i >= 32});
      chk("ready_c", {63'd0, ready_c}, {63'd0, i >= 16});
      if (i == 31) begin
        chk("sweep_rd", rd_data_a, 64'd0);
        chk("sweep_pend", {62'd0, rd_pend_a}, 64'd0);
      end
    end
    idle();
    @(negedge clk);
    chk("post_sweep_rd", rd_data_a, 64'd0);
    chk("post_sweep_pend", {62'd0, rd_pend_a}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      wr_en    = vt[i].we;
      wr_addr  = vt[i].wa;
      wr_data  = vt[i].wd;
      rsv_en   = vt[i].re;
      rsv_addr = vt[i].ra;
      rd_addr  = {vt[i].a1, vt[i].a0};
      q.push_back(vt[i]);
      @(negedge clk);
      e = q.pop_front();
      chk($sformatf("v%0d_d0", i), {32'd0, rd_data_a[31:0]},
          {32'd0, e.d0});
      chk($sformatf("v%0d_d1", i), {32'd0, rd_data_a[63:32]},
          {32'd0, e.d1});
      chk($sformatf("v%0d_p", i), {62'd0, rd_pend_a},
          {62'd0, e.p1, e.p0});
      chk($sformatf("v%0d_nb", i), {32'd0, rd_data_b[31:0]},
          {32'd0, e.nb0});
    end
    @(posedge clk); #1;
    idle();

    wr2(4'd1, 64'h1111_2222_3333_4444);
    wr2(4'd2, 64'h5555_6666_7777_8888);
    wr2(4'd15, 64'hFEDC_BA98_7654_3210);
    wr2(4'd0, 64'h0BAD_0BAD_0BAD_0BAD);
    rd3(4'd1, 4'd2, 4'd15,
        64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
        64'hFEDC_BA98_7654_3210);
    rd3(4'd15, 4'd0, 4'd1,
        64'hFEDC_BA98_7654_3210, 64'd0,
        64'h1111_2222_3333_4444);

    // restart the sweep, then interrupt it at cnt==10
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_not_ready", {63'd0, ready_a}, 64'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_addr = {5'd7, 5'd5};
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      chk("mid_ready", {63'd0, ready_a}, {63'd0, i >= 32});
    end
    @(negedge clk);
    chk("mid_rd5_7", rd_data_a, 64'd0);
    rd_addr = {5'd31, 5'd3};
    @(negedge clk);
    chk("mid_rd3_31", rd_data_a, 64'd0);
    chk("mid_pend3", {62'd0, rd_pend_a}, 64'd0);
    rd3(4'd1, 4'd2, 4'd15, 64'd0, 64'd0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
